// File: rtl/ciphertext_affine_normalizer_pkg.sv
// Shared types and GF(2^N) helpers for the ciphertext affine normalizer.
// Optional Z==0 flag outputs are enabled with NORM_INF_FLAG_EN.
package ciphertext_affine_normalizer_pkg;

  localparam int N_DEF = 3;
  localparam logic [N_DEF-1:0] POLY_DEF = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INV_SQ,
    S_INV_MUL,
    S_MUL_X,
    S_MUL_Y,
    S_NEXT,
    S_DONE
  } state_t;

  // v*x reduced by the low-N-bit polynomial; n must be <= 31
  function automatic logic [31:0] gf_reduce(
    input logic [31:0] v,
    input logic [31:0] poly,
    input int          n
  );
    logic [31:0] mask;
    logic        msb;
    mask = (32'd1 << n) - 32'd1;
    msb  = ((v >> (n - 1)) & 32'd1) != 32'd0;
    return ((v << 1) & mask) ^ (msb ? poly : 32'd0);
  endfunction

endpackage

// File: rtl/ciphertext_affine_normalizer_mul.sv
// Bit-serial MSB-first GF(2^N) multiplier, N cycles per product.
// Step 0 runs in the go cycle; p is valid combinationally while rdy is high.
module gf2m_serial_mul
  import ciphertext_affine_normalizer_pkg::*;
#(
  parameter int N = N_DEF,
  parameter logic [N-1:0] POLY = POLY_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         go,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] p,
  output logic         rdy
);

  localparam int CW = $clog2(N) + 1;

  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic [N-1:0]  acc_r;
  logic [N-1:0]  acc_nx;
  logic [CW-1:0] cnt;
  logic          active;

  always_comb begin
    acc_nx = N'(gf_reduce(32'(acc_r), 32'(POLY), N));
    acc_nx = acc_nx ^ (b_r[N-1] ? a_r : '0);
  end

  assign p   = acc_nx;
  assign rdy = active && (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r    <= '0;
      b_r    <= '0;
      acc_r  <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (go) begin
      a_r    <= a;
      b_r    <= b << 1;
      acc_r  <= b[N-1] ? a : '0;
      cnt    <= CW'(1);
      active <= 1'b1;
    end else if (active) begin
      acc_r <= acc_nx;
      b_r   <= b_r << 1;
      cnt   <= cnt + CW'(1);
      if (rdy) active <= 1'b0;
    end
  end

endmodule

// File: rtl/ciphertext_affine_normalizer.sv
// Projective-to-affine converter for EC-ElGamal ciphertext points over GF(2^N).
// Define NORM_INF_FLAG_EN to add the c1_inf/c2_inf Z==0 flag outputs.
module ciphertext_affine_normalizer
  import ciphertext_affine_normalizer_pkg::*;
#(
  parameter int N = N_DEF,
  parameter logic [N-1:0] POLY = POLY_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] x_C1,
  input  logic [N-1:0] y_C1,
  input  logic [N-1:0] z_C1,
  input  logic [N-1:0] x_C2,
  input  logic [N-1:0] y_C2,
  input  logic [N-1:0] z_C2,
  output logic [N-1:0] ax_C1,
  output logic [N-1:0] ay_C1,
  output logic [N-1:0] ax_C2,
  output logic [N-1:0] ay_C2,
  output logic         busy,
  output logic         done
`ifdef NORM_INF_FLAG_EN
  ,
  output logic         c1_inf,
  output logic         c2_inf
`endif
);

  localparam int RW = $clog2(N);

  state_t        state;
  logic          pt;
  logic          first;
  logic [RW-1:0] rnd;
  logic [N-1:0]  t;
  logic [N-1:0]  acc;
  logic [N-1:0]  px [2];
  logic [N-1:0]  py [2];
  logic [N-1:0]  pz [2];
  logic [N-1:0]  rx [2];
  logic [N-1:0]  ry [2];
  logic          accept;
  logic          go;
  logic [N-1:0]  ma;
  logic [N-1:0]  mb;
  logic [N-1:0]  p;
  logic          rdy;

  assign accept = start && (state == S_IDLE || state == S_DONE);

  // LOAD and NEXT double as the first cycle of each point's first square
  always_comb begin
    go = first;
    ma = t;
    mb = t;
    case (state)
      S_LOAD: begin
        go = 1'b1;
        ma = pz[0];
        mb = pz[0];
      end
      S_NEXT: begin
        go = !pt;
        ma = pz[1];
        mb = pz[1];
      end
      S_INV_MUL: begin
        ma = acc;
        mb = t;
      end
      S_MUL_X: begin
        ma = px[pt];
        mb = acc;
      end
      S_MUL_Y: begin
        ma = py[pt];
        mb = acc;
      end
      default: ;
    endcase
  end

  gf2m_serial_mul #(.N(N), .POLY(POLY)) u_mul (
    .clk  (clk),
    .reset(reset),
    .go   (go),
    .a    (ma),
    .b    (mb),
    .p    (p),
    .rdy  (rdy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        px[i] <= '0;
        py[i] <= '0;
        pz[i] <= '0;
      end
    end else if (accept) begin
      px[0] <= x_C1;
      py[0] <= y_C1;
      pz[0] <= z_C1;
      px[1] <= x_C2;
      py[1] <= y_C2;
      pz[1] <= z_C2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      pt    <= 1'b0;
      first <= 1'b0;
      rnd   <= '0;
      t     <= '0;
      acc   <= '0;
      for (int i = 0; i < 2; i++) begin
        rx[i] <= '0;
        ry[i] <= '0;
      end
      ax_C1 <= '0;
      ay_C1 <= '0;
      ax_C2 <= '0;
      ay_C2 <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef NORM_INF_FLAG_EN
      c1_inf <= 1'b0;
      c2_inf <= 1'b0;
`endif
    end else begin
      first <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          acc   <= N'(1);
          pt    <= 1'b0;
          rnd   <= '0;
          state <= S_INV_SQ;
        end
        S_INV_SQ: begin
          if (rdy) begin
            t     <= p;
            first <= 1'b1;
            state <= S_INV_MUL;
          end
        end
        S_INV_MUL: begin
          if (rdy) begin
            acc   <= p;
            first <= 1'b1;
            if (rnd == RW'(N - 2)) begin
              rnd   <= '0;
              state <= S_MUL_X;
            end else begin
              rnd   <= rnd + RW'(1);
              state <= S_INV_SQ;
            end
          end
        end
        S_MUL_X: begin
          if (rdy) begin
            rx[pt] <= p;
            first  <= 1'b1;
            state  <= S_MUL_Y;
          end
        end
        S_MUL_Y: begin
          if (rdy) begin
            ry[pt] <= p;
            state  <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (!pt) begin
            pt    <= 1'b1;
            acc   <= N'(1);
            state <= S_INV_SQ;
          end else begin
            ax_C1 <= rx[0];
            ay_C1 <= ry[0];
            ax_C2 <= rx[1];
            ay_C2 <= ry[1];
            done  <= 1'b1;
`ifdef NORM_INF_FLAG_EN
            c1_inf <= (pz[0] == '0);
            c2_inf <= (pz[1] == '0);
`endif
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (accept) begin
            state <= S_LOAD;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ciphertext_affine_normalizer.sv
// Directed bench for ciphertext_affine_normalizer, N=3, POLY=x^3+x+1.
// Flag checks are compiled in with NORM_INF_FLAG_EN.
module tb_ciphertext_affine_normalizer;

  typedef struct {
    logic [2:0] x1, y1, z1, x2, y2, z2;
    logic [2:0] ax1, ay1, ax2, ay2;
    logic       i1, i2;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] x_C1, y_C1, z_C1, x_C2, y_C2, z_C2;
  logic [2:0] ax_C1, ay_C1, ax_C2, ay_C2;
  logic       busy, done;
`ifdef NORM_INF_FLAG_EN
  logic       c1_inf, c2_inf;
`endif

  int   tests  = 0;
  int   failed = 0;
  int   cyc    = 0;
  vec_t vt[5];

  always #5 clk = ~clk;

  ciphertext_affine_normalizer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x_C1  (x_C1),
    .y_C1  (y_C1),
    .z_C1  (z_C1),
    .x_C2  (x_C2),
    .y_C2  (y_C2),
    .z_C2  (z_C2),
    .ax_C1 (ax_C1),
    .ay_C1 (ay_C1),
    .ax_C2 (ax_C2),
    .ay_C2 (ay_C2),
    .busy  (busy),
    .done  (done)
`ifdef NORM_INF_FLAG_EN
    ,
    .c1_inf(c1_inf),
    .c2_inf(c2_inf)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply(input vec_t v);
    x_C1 = v.x1; y_C1 = v.y1; z_C1 = v.z1;
    x_C2 = v.x2; y_C2 = v.y2; z_C2 = v.z2;
  endtask

  // returns in cycle 1 (first cycle after the sampling edge)
  task automatic pulse_start(input vec_t v);
    apply(v);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done(output int at);
    while (done !== 1'b1 && cyc < 60) tick();
    at = cyc;
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (done === 1'b1) cnt++;
    end
  endtask

  task automatic check_out(input string tag, input vec_t v);
    chk({tag, ".ax_C1"}, 32'(ax_C1), 32'(v.ax1));
    chk({tag, ".ay_C1"}, 32'(ay_C1), 32'(v.ay1));
    chk({tag, ".ax_C2"}, 32'(ax_C2), 32'(v.ax2));
    chk({tag, ".ay_C2"}, 32'(ay_C2), 32'(v.ay2));
`ifdef NORM_INF_FLAG_EN
    chk({tag, ".c1_inf"}, 32'(c1_inf), 32'(v.i1));
    chk({tag, ".c2_inf"}, 32'(c2_inf), 32'(v.i2));
`endif
  endtask

  initial begin
    int at;
    int nd;

    // powers of a: 1,2,4,3,6,7,5
    vt[0] = '{3'd6, 3'd1, 3'd1, 3'd3, 3'd1, 3'd2, 3'd6, 3'd1, 3'd4, 3'd5, 1'b0, 1'b0};
    vt[1] = '{3'd3, 3'd3, 3'd3, 3'd7, 3'd5, 3'd4, 3'd1, 3'd1, 3'd3, 3'd6, 1'b0, 1'b0};
    vt[2] = '{3'd5, 3'd2, 3'd7, 3'd6, 3'd7, 3'd0, 3'd2, 3'd3, 3'd0, 3'd0, 1'b0, 1'b1};
    vt[3] = '{3'd0, 3'd7, 3'd6, 3'd1, 3'd1, 3'd5, 3'd0, 3'd2, 3'd2, 3'd2, 1'b0, 1'b0};
    vt[4] = '{3'd7, 3'd7, 3'd0, 3'd4, 3'd6, 3'd3, 3'd0, 3'd0, 3'd5, 3'd2, 1'b1, 1'b0};

    reset = 1'b0;
    start = 1'b0;
    apply(vt[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    check_out("rst", '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    reset = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      pulse_start(vt[i]);
      chk($sformatf("v%0d.busy1", i), 32'(busy), 1);
      chk($sformatf("v%0d.done1", i), 32'(done), 0);
      wait_done(at);
      chk($sformatf("v%0d.latency", i), 32'(at), 38);
      chk($sformatf("v%0d.busy_done", i), 32'(busy), 1);
      check_out($sformatf("v%0d", i), vt[i]);
      tick();
      chk($sformatf("v%0d.done_pulse", i), 32'(done), 0);
      chk($sformatf("v%0d.busy_end", i), 32'(busy), 0);
      check_out($sformatf("v%0d.hold", i), vt[i]);
      tick();
    end

    // start while busy is ignored and inputs are not resampled
    pulse_start(vt[1]);
    while (cyc < 10) tick();
    apply(vt[2]);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(at);
    chk("ign.latency", 32'(at), 38);
    check_out("ign", vt[1]);
    count_done(45, nd);
    chk("ign.extra_done", 32'(nd), 0);
    chk("ign.busy_idle", 32'(busy), 0);

    // asynchronous reset in the middle of a run
    pulse_start(vt[3]);
    while (cyc < 20) tick();
    reset = 1'b0;
    #1;
    chk("abort.busy", 32'(busy), 0);
    chk("abort.done", 32'(done), 0);
    check_out("abort", '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    tick();
    tick();
    reset = 1'b1;
    count_done(45, nd);
    chk("abort.no_done", 32'(nd), 0);
    pulse_start(vt[3]);
    wait_done(at);
    chk("rerun.latency", 32'(at), 38);
    check_out("rerun", vt[3]);

    // start coincident with done
    tick();
    pulse_start(vt[4]);
    wait_done(at);
    chk("b2b.first_latency", 32'(at), 38);
    check_out("b2b.first", vt[4]);
    pulse_start(vt[0]);
    chk("b2b.busy1", 32'(busy), 1);
    chk("b2b.done1", 32'(done), 0);
    check_out("b2b.hold", vt[4]);
    wait_done(at);
    chk("b2b.second_latency", 32'(at), 38);
    check_out("b2b.second", vt[0]);
    tick();
    chk("b2b.busy_end", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
